// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// with a valid/ready handshake on both operand and result sides.
module chunked_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  // Guard against CHUNK == 0 so the illegal-parameter check below is what reports it.
  localparam int unsigned N       = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;       // already inverted for subtraction
  logic              c_q, c_d;       // running inter-chunk carry
  logic [WIDTH-1:0]  y_q, y_d;
  logic              carry_q, carry_d;
  logic              overflow_q, overflow_d;
  logic              zero_q, zero_d;

  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic [CHUNK:0]    chunk_sum;

  // Select the active chunk of each captured operand and add it with the running carry.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CntW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer and the datapath registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    y_d        = y_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b ^ {WIDTH{sub}};
          c_d        = sub;
          cnt_d      = '0;
          y_d        = '0;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          zero_d     = 1'b0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CntW'(i)) begin
            y_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
          end
        end
        c_d   = chunk_sum[CHUNK];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          carry_d    = chunk_sum[CHUNK];
          // Signed overflow: like-signed operands produced an opposite-signed result.
          overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d     = (y_d == '0);
          state_d    = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      y_q        <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      y_q        <= y_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  // Handshake and result outputs straight from state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    y         = y_q;
    carry     = carry_q;
    overflow  = overflow_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench: three instances (CHUNK = 8, 32, 1) checked against an
// arithmetic reference model, plus directed backpressure and reset-abort cases.
module tb_chunked_adder;

  localparam int NLAT [3] = '{4, 1, 32};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_v, b_v;
  logic        sub_v;
  logic        iv   [3];
  logic        ordy [3];
  logic        irdy [3];
  logic        ovld [3];
  logic [31:0] y_w  [3];
  logic        cy_w [3];
  logic        of_w [3];
  logic        zr_w [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a_v), .b(b_v),
    .sub(sub_v), .out_valid(ovld[0]), .out_ready(ordy[0]), .y(y_w[0]), .carry(cy_w[0]),
    .overflow(of_w[0]), .zero(zr_w[0])
  );
  chunked_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a_v), .b(b_v),
    .sub(sub_v), .out_valid(ovld[1]), .out_ready(ordy[1]), .y(y_w[1]), .carry(cy_w[1]),
    .overflow(of_w[1]), .zero(zr_w[1])
  );
  chunked_adder #(.WIDTH(32), .CHUNK(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a_v), .b(b_v),
    .sub(sub_v), .out_valid(ovld[2]), .out_ready(ordy[2]), .y(y_w[2]), .carry(cy_w[2]),
    .overflow(of_w[2]), .zero(zr_w[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain 32-bit arithmetic on the original operands.
  task automatic model(input logic [31:0] x, input logic [31:0] z, input logic s,
                       output logic [31:0] r, output logic c, output logic o, output logic zf);
    if (!s) begin
      {c, r} = {1'b0, x} + {1'b0, z};
      o = (x[31] == z[31]) && (r[31] != x[31]);
    end else begin
      r = x - z;
      c = (x >= z);
      o = (x[31] != z[31]) && (r[31] != x[31]);
    end
    zf = (r == 32'h0);
  endtask

  // Issue one operation to instance idx, check latency and result, then retire it.
  task automatic run_op(input int idx, input logic [31:0] ai, input logic [31:0] bi,
                        input logic si, input string tag);
    logic [31:0] er;
    logic ec, eo, ez;
    int lat;
    model(ai, bi, si, er, ec, eo, ez);
    @(negedge clk);
    a_v = ai; b_v = bi; sub_v = si; iv[idx] = 1'b1;
    check_eq({tag, "/in_ready"}, 32'(irdy[idx]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv[idx] = 1'b0;
    lat = 0;
    while (!ovld[idx] && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq({tag, "/latency"}, 32'(lat), 32'(NLAT[idx]));
    check_eq({tag, "/y"}, y_w[idx], er);
    check_eq({tag, "/carry"}, 32'(cy_w[idx]), 32'(ec));
    check_eq({tag, "/overflow"}, 32'(of_w[idx]), 32'(eo));
    check_eq({tag, "/zero"}, 32'(zr_w[idx]), 32'(ez));
    ordy[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[idx] = 1'b0;
    check_eq({tag, "/back_idle"}, 32'(irdy[idx]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_y, er;
    logic held_c, held_o, held_z, ec, eo, ez;
    int lat;

    reset = 1'b1; a_v = '0; b_v = '0; sub_v = 1'b0;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst%0d/in_ready", i), 32'(irdy[i]), 32'd1);
      check_eq($sformatf("rst%0d/out_valid", i), 32'(ovld[i]), 32'd0);
      check_eq($sformatf("rst%0d/y", i), y_w[i], 32'd0);
      check_eq($sformatf("rst%0d/flags", i), {29'd0, cy_w[i], of_w[i], zr_w[i]}, 32'd0);
    end

    // Reset has priority over in_valid in IDLE.
    iv[0] = 1'b1; a_v = 32'h1; b_v = 32'h1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    reset = 1'b0;
    check_eq("rst_prio/in_ready", 32'(irdy[0]), 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_prio/out_valid", 32'(ovld[0]), 32'd0);

    // Directed vectors on every chunk size.
    for (int i = 0; i < 3; i++) begin
      run_op(i, 32'h000000FF, 32'h00000001, 1'b0, $sformatf("ff_plus_1/n%0d", NLAT[i]));
      run_op(i, 32'hFFFFFFFF, 32'h00000001, 1'b0, $sformatf("wrap/n%0d", NLAT[i]));
      run_op(i, 32'h80000000, 32'h00000001, 1'b1, $sformatf("min_minus_1/n%0d", NLAT[i]));
      run_op(i, 32'h00000005, 32'h00000007, 1'b1, $sformatf("5_minus_7/n%0d", NLAT[i]));
    end

    // Backpressure: hold DONE while new operands are offered.
    @(negedge clk);
    a_v = 32'h0000_1234; b_v = 32'h0000_4321; sub_v = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    lat = 0;
    while (!ovld[0] && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq("bp/latency", 32'(lat), 32'd4);
    model(32'h0000_1234, 32'h0000_4321, 1'b0, er, ec, eo, ez);
    check_eq("bp/y", y_w[0], er);
    held_y = y_w[0]; held_c = cy_w[0]; held_o = of_w[0]; held_z = zr_w[0];
    a_v = 32'hDEAD_BEEF; b_v = 32'h0BAD_F00D; sub_v = 1'b1; iv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("bp%0d/y_stable", k), y_w[0], held_y);
      check_eq($sformatf("bp%0d/flags_stable", k), {29'd0, cy_w[0], of_w[0], zr_w[0]},
               {29'd0, held_c, held_o, held_z});
      check_eq($sformatf("bp%0d/in_ready", k), 32'(irdy[0]), 32'd0);
      check_eq($sformatf("bp%0d/out_valid", k), 32'(ovld[0]), 32'd1);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;
    check_eq("bp/idle", 32'(irdy[0]), 32'd1);
    check_eq("bp/no_capture_y", y_w[0], held_y);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("bp/no_capture_valid", 32'(ovld[0]), 32'd0);

    // Reset sampled on the 2nd BUSY edge aborts the operation.
    a_v = 32'hAAAA_AAAA; b_v = 32'h5555_5555; sub_v = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort/in_ready", 32'(irdy[0]), 32'd1);
    check_eq("abort/out_valid", 32'(ovld[0]), 32'd0);
    check_eq("abort/y", y_w[0], 32'd0);
    run_op(0, 32'h12345678, 32'h11111111, 1'b0, "after_abort");
    check_eq("after_abort/y_const", y_w[0], 32'h23456789);

    // Randomized operations on all three instances.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 25; k++) begin
        logic [31:0] ra, rb;
        ra = $urandom;
        rb = (k % 5 == 0) ? ra : $urandom;
        if (k % 7 == 3) ra = {ra[31], 31'h0};
        run_op(i, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd/n%0d/%0d", NLAT[i], k));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 32, operand and result width in bits.
REQ-003 Parameter CHUNK, default 8, bits added per cycle; N = WIDTH/CHUNK chunk steps.
REQ-004 Elaboration SHALL fail if CHUNK < 1, CHUNK > WIDTH, or WIDTH % CHUNK != 0.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operands presented.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 sub  input  1  0 computes a+b; 1 computes a-b.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 y  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-015 carry  output  1  unsigned carry-out; for sub, 1 = no borrow (a >= b unsigned).
REQ-016 overflow  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  1 when y == 0.

Function
REQ-018 The FSM SHALL have states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-019 IDLE: on in_valid at an edge, capture a, b XOR {WIDTH{sub}}, carry-in = sub, chunk counter = 0; go to BUSY. Otherwise hold.
REQ-020 BUSY: on each edge, add chunk[counter] of both captured operands plus the running carry; write the CHUNK-bit sum into y at chunk position counter (LSB chunk first); store the chunk carry-out; increment counter.
REQ-021 BUSY SHALL last exactly N edges; on the edge that processes chunk N-1, go to DONE and register the carry, overflow and zero flags.
REQ-022 Latency: if operands are accepted at edge t, out_valid SHALL be high from edge t+N; with CHUNK == WIDTH, N = 1.
REQ-023 overflow SHALL be 1 iff the captured operand MSBs are equal and the y MSB differs from them; the captured operand B is the inverted B for sub.
REQ-024 DONE: y, carry, overflow and zero SHALL hold stable until out_ready is sampled high, then go to IDLE; with no out_ready, hold indefinitely.
REQ-025 in_valid during BUSY or DONE SHALL be ignored: no capture and no effect on the running operation.
REQ-026 The block SHALL not overlap operations; at most one operation is in flight, and throughput is one result per N+2 cycles minimum.
REQ-027 y, carry, overflow and zero SHALL change only at IDLE-to-BUSY (y cleared to 0, flags to 0), during BUSY (y chunks), and at BUSY-to-DONE (flags).
REQ-028 The result SHALL equal the combinational a+b or a-b modulo 2^WIDTH for all operand values.

Reset
REQ-029 reset sampled high SHALL force state to IDLE, counter, y, carry, overflow and zero to 0, in_ready to 1 and out_valid to 0 on that edge.
REQ-030 reset SHALL have priority over all other inputs, including in_valid in IDLE; reset during BUSY or DONE SHALL abort the operation with no result output.
REQ-031 After reset deasserts, the next in_valid SHALL start a clean operation unaffected by the aborted one.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-032 a=0x000000FF, b=0x00000001, sub=0, accepted at edge t -> out_valid high from edge t+4; y=0x00000100; carry=0; overflow=0; zero=0.
REQ-033 a=0xFFFFFFFF, b=0x00000001, sub=0 -> y=0x00000000; carry=1; zero=1; overflow=0.
REQ-034 a=0x80000000, b=0x00000001, sub=1 -> y=0x7FFFFFFF; carry=1; overflow=1. Then a=5, b=7, sub=1 -> y=0xFFFFFFFE; carry=0; overflow=0.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> y and flags stable, in_ready=0, no capture; out_ready=1 -> IDLE next edge.
REQ-036 Reset at the 2nd BUSY edge -> next cycle in_ready=1, out_valid=0, y=0; a following 0x12345678+0x11111111 -> y=0x23456789.
REQ-037 Rerun REQ-032/033 with CHUNK=32 (N=1) and CHUNK=1 (N=32): identical results, latency N.
